wr_txn_tracker: RTL and testbench
=================================

// Module: wr_txn_tracker
// PURPOSE
//  Per-slot write-transaction watchdog for the AXI monitor; write-side counterpart of the read slot counter.
//  One instance per outstanding-write slot. Follows a write through AW-accepted -> W data -> B response.
//  Runs a prescaled timeout budget for each phase and raises sticky timeout/protocol flags to the monitor top.
// PARAMETERS
//  CntWidth   10  width of the phase budget counter
//  IdWidth    4   AXI ID width
//  LenWidth   8   AXI AxLEN width; the beat counter is LenWidth+1 bits
// PORTS
//  clk_i           in   1          clock
//  rst_ni          in   1          asynchronous reset, active-low
//  prescaled_en_i  in   1          1-cycle tick from the shared prescaler
//  alloc_i         in   1          AW handshake assigned to this slot
//  alloc_id_i      in   IdWidth    AWID of the allocating transaction
//  alloc_len_i     in   LenWidth   AWLEN of the allocating transaction
//  budget_w_i      in   CntWidth   ticks allowed from AW to the first W beat
//  budget_last_i   in   CntWidth   ticks allowed between consecutive W beats
//  budget_b_i      in   CntWidth   ticks allowed from WLAST to B
//  w_beat_i        in   1          W handshake routed to this slot (the top enforces W order)
//  w_last_i        in   1          WLAST qualifier for w_beat_i
//  b_hs_i          in   1          B handshake whose BID the top matched to this slot
//  clear_i         in   1          synchronous slot abort (isolation/recovery)
//  free_o          out  1          slot idle, may be allocated
//  id_o            out  IdWidth    stored ID
//  phase_o         out  2          wr_phase_e
//  counter_o       out  CntWidth   remaining budget of the current phase
//  timeout_o       out  1          sticky: a phase budget expired
//  len_err_o       out  1          sticky: WLAST beat count differs from AWLEN+1
//  proto_err_o     out  1          sticky: B arrived before WLAST
//  alloc_err_o     out  1          1-cycle pulse: alloc_i while the slot is busy
// BEHAVIOUR
//  Reset:
//   - phase=IDLE, free_o=1; id, counter, beats and all flags = 0.
//  FSM wr_phase_e: IDLE(0), W_FIRST(1), W_LAST(2), B_WAIT(3). free_o = (phase==IDLE), registered.
//  IDLE + alloc_i:
//   - latch id and len, beats=0, clear all sticky flags.
//   - no beat -> W_FIRST, counter=budget_w_i.
//   - w_beat_i, no last -> W_LAST, beats=1, counter=budget_last_i.
//   - w_beat_i & w_last_i -> B_WAIT, counter=budget_b_i; len check applied.
//  W_FIRST + w_beat_i: beats+1. No last -> W_LAST with budget_last_i. Last -> B_WAIT with budget_b_i.
//  W_LAST + w_beat_i: beats+1 and reload budget_last_i. If last -> B_WAIT with budget_b_i.
//  Length check on every last beat:
//   - len_err_o set if beats_after_increment != len+1.
//   - A non-last beat that makes beats > len+1 also sets len_err_o.
//  B_WAIT + b_hs_i: -> IDLE. Flags hold until the next alloc so the top can sample them.
//  W_FIRST/W_LAST + b_hs_i: proto_err_o=1, -> IDLE.
//  Budget counter (busy phases only):
//   - prescaled_en_i & counter!=0 -> counter-1.
//   - prescaled_en_i & counter==0 -> timeout_o=1; counter saturates at 0.
//   - Timeout does not change phase; the slot keeps tracking until B or clear_i.
//  Priority within a cycle:
//   - clear_i > phase-advancing event (reload) > decrement.
//   - A beat and a tick in the same cycle reload the counter with no decrement.
//  clear_i: any phase -> IDLE, counter=0. Sticky flags are kept.
//  alloc_i while busy: state untouched, alloc_err_o pulses for 1 cycle.
//  Events in IDLE without alloc_i: w_beat_i and b_hs_i are ignored.
//  Widths:
//   - beats is LenWidth+1 bits, so len=255 -> 256 beats with no wrap.
//   - Beats past 2^(LenWidth+1)-1 saturate (len_err_o is already set).
//   - Budget 0 at phase entry -> timeout_o on the first tick.
//  Latency: all outputs are registered; the effect of an input is visible the cycle after it is sampled.
//  Reset mid-operation: asynchronous return to the reset state; the in-flight transaction is forgotten.
// STRUCTURE
//  axi_monitor_pkg:
//   - wr_phase_e enum.
//   - wr_slot_t struct {free, id, len, beats, phase, counter, flags}.
//   - Error-flag bit positions.
//  One sub-module, tmo_budget_cnt:
//   - load / tick / saturating-decrement counter with an expired flag.
//   - Parameter CntWidth; reusable by the read side.
//  FSM and flag logic stay in wr_txn_tracker.
// TESTING
//  1. Nominal burst: alloc id=3 len=3, 4 beats with last on the 4th, B 5 cycles later.
//     -> phases 1,2,3,0; no flags; free_o=1 after B.
//  2. W timeout: alloc budget_w=2, prescaler ticking every cycle, no W.
//     -> counter 2,1,0; timeout_o=1 on the 3rd tick; phase stays W_FIRST.
//  3. Same-cycle AW+W: alloc with w_beat_i=1, w_last_i=1, len=0.
//     -> next cycle phase=B_WAIT, counter=budget_b, len_err_o=0.
//  4. Length mismatch: len=1, last on beat 3.
//     -> len_err_o=1, phase=B_WAIT.
//     Also: len=3, last on beat 2 -> len_err_o=1.
//  5. Early B: b_hs_i during W_LAST -> proto_err_o=1, free_o=1.
//     Then alloc_i while busy -> alloc_err_o pulse with state unchanged.
//  6. Abort and reset: clear_i together with w_beat_i and a tick -> IDLE, counter 0.
//     rst_ni low in B_WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/axi_monitor_pkg.sv
// Shared types for the AXI monitor write-slot tracking.
// Contents: write-phase enum, error-flag bit positions, slot snapshot struct.
package axi_monitor_pkg;

    localparam int unsigned CntWidthDef = 10;
    localparam int unsigned IdWidthDef  = 4;
    localparam int unsigned LenWidthDef = 8;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_W_FIRST = 2'd1,
        WR_W_LAST  = 2'd2,
        WR_B_WAIT  = 2'd3
    } wr_phase_e;

    // Bit positions inside the sticky error-flag vector
    localparam int unsigned ErrTimeout = 0;
    localparam int unsigned ErrLen     = 1;
    localparam int unsigned ErrProto   = 2;
    localparam int unsigned ErrNum     = 3;

    typedef logic [ErrNum-1:0] wr_err_t;

    // Snapshot of one write slot at default widths, for the monitor top
    typedef struct packed {
        logic                   free;
        logic [IdWidthDef-1:0]  id;
        logic [LenWidthDef-1:0] len;
        logic [LenWidthDef:0]   beats;
        wr_phase_e              phase;
        logic [CntWidthDef-1:0] counter;
        wr_err_t                flags;
    } wr_slot_t;

endpackage

// File: rtl/wr_txn_tracker_if.sv
// Bus bundle between the monitor top (master) and one write slot tracker (slave).
// Master drives tick, allocation, budgets, W/B events and abort; slave returns
// slot status and error flags.
interface wr_txn_tracker_if
    import axi_monitor_pkg::*;
#(
    parameter int unsigned CntWidth = 10,
    parameter int unsigned IdWidth  = 4,
    parameter int unsigned LenWidth = 8
);
    logic                prescaled_en_i;
    logic                alloc_i;
    logic [IdWidth-1:0]  alloc_id_i;
    logic [LenWidth-1:0] alloc_len_i;
    logic [CntWidth-1:0] budget_w_i;
    logic [CntWidth-1:0] budget_last_i;
    logic [CntWidth-1:0] budget_b_i;
    logic                w_beat_i;
    logic                w_last_i;
    logic                b_hs_i;
    logic                clear_i;

    logic                free_o;
    logic [IdWidth-1:0]  id_o;
    wr_phase_e           phase_o;
    logic [CntWidth-1:0] counter_o;
    logic                timeout_o;
    logic                len_err_o;
    logic                proto_err_o;
    logic                alloc_err_o;

    modport master (
        output prescaled_en_i, alloc_i, alloc_id_i, alloc_len_i,
               budget_w_i, budget_last_i, budget_b_i,
               w_beat_i, w_last_i, b_hs_i, clear_i,
        input  free_o, id_o, phase_o, counter_o,
               timeout_o, len_err_o, proto_err_o, alloc_err_o
    );

    modport slave (
        input  prescaled_en_i, alloc_i, alloc_id_i, alloc_len_i,
               budget_w_i, budget_last_i, budget_b_i,
               w_beat_i, w_last_i, b_hs_i, clear_i,
        output free_o, id_o, phase_o, counter_o,
               timeout_o, len_err_o, proto_err_o, alloc_err_o
    );

endinterface

// File: rtl/tmo_budget_cnt.sv
// Load / tick / saturating-decrement budget counter.
// Ports: clk_i, rst_ni (async active-low), clr (force to 0), load + load_val
// (reload), tick (decrement request), count (registered value),
// expired_c (combinational: a tick landed on an empty budget).
// Priority: clr > load > tick.
module tmo_budget_cnt #(
    parameter int unsigned CntWidth = 10
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr,
    input  logic                load,
    input  logic [CntWidth-1:0] load_val,
    input  logic                tick,
    output logic [CntWidth-1:0] count,
    output logic                expired_c
);

    logic tick_eff;

    assign tick_eff  = tick && !clr && !load;
    assign expired_c = tick_eff && (count == '0);

    // Counter register; saturates at zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick_eff && (count != '0)) begin
            count <= count - CntWidth'(1);
        end
    end

endmodule

// File: rtl/wr_txn_tracker.sv
// Per-slot write-transaction watchdog: follows AW -> W beats -> B for one
// outstanding-write slot, runs a prescaled budget per phase and raises sticky
// timeout / length / protocol flags plus an alloc-while-busy pulse.
// Ports: clk_i, rst_ni (async active-low), bus (wr_txn_tracker_if.slave):
//   inputs  prescaled_en_i, alloc_i/_id_i/_len_i, budget_w/_last/_b_i,
//           w_beat_i, w_last_i, b_hs_i, clear_i
//   outputs free_o, id_o, phase_o, counter_o, timeout_o, len_err_o,
//           proto_err_o, alloc_err_o (all registered)
module wr_txn_tracker
    import axi_monitor_pkg::*;
#(
    parameter int unsigned CntWidth = 10,
    parameter int unsigned IdWidth  = 4,
    parameter int unsigned LenWidth = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    wr_txn_tracker_if.slave  bus
);

    localparam int unsigned BeatWidth = LenWidth + 1;

    wr_phase_e            phase_q, phase_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [LenWidth-1:0]  len_q, len_d;
    logic [BeatWidth-1:0] beats_q, beats_d;
    wr_err_t              flags_q, flags_d;
    logic                 free_q, free_d;
    logic                 alloc_err_q, alloc_err_d;

    logic                 busy_c;
    logic [BeatWidth-1:0] beat_next_c;
    logic [BeatWidth-1:0] len_ref_c;
    logic                 len_bad_c;

    logic                 cnt_clr, cnt_load, cnt_tick, cnt_expired_c;
    logic [CntWidth-1:0]  cnt_load_val, cnt_value;

    assign busy_c = (phase_q != WR_IDLE);

    // Beat count after the current beat (first beat when allocating); saturates
    assign beat_next_c = !busy_c ? BeatWidth'(1)
                       : ((beats_q == '1) ? beats_q : beats_q + BeatWidth'(1));
    assign len_ref_c   = !busy_c ? BeatWidth'(bus.alloc_len_i) + BeatWidth'(1)
                       : BeatWidth'(len_q) + BeatWidth'(1);
    assign len_bad_c   = bus.w_last_i ? (beat_next_c != len_ref_c)
                                      : (beat_next_c > len_ref_c);

    // Budget decrements only in busy phases; reload/clear suppress it inside the counter
    assign cnt_tick = bus.prescaled_en_i && busy_c;

    tmo_budget_cnt #(
        .CntWidth (CntWidth)
    ) u_budget (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr       (cnt_clr),
        .load      (cnt_load),
        .load_val  (cnt_load_val),
        .tick      (cnt_tick),
        .count     (cnt_value),
        .expired_c (cnt_expired_c)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q     <= WR_IDLE;
            id_q        <= '0;
            len_q       <= '0;
            beats_q     <= '0;
            flags_q     <= '0;
            free_q      <= 1'b1;
            alloc_err_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            id_q        <= id_d;
            len_q       <= len_d;
            beats_q     <= beats_d;
            flags_q     <= flags_d;
            free_q      <= free_d;
            alloc_err_q <= alloc_err_d;
        end
    end

    // Next-phase logic
    always_comb begin
        phase_d = phase_q;
        if (bus.clear_i) begin
            phase_d = WR_IDLE;
        end else begin
            unique case (phase_q)
                WR_IDLE: begin
                    if (bus.alloc_i) begin
                        if (!bus.w_beat_i)     phase_d = WR_W_FIRST;
                        else if (bus.w_last_i) phase_d = WR_B_WAIT;
                        else                   phase_d = WR_W_LAST;
                    end
                end
                WR_W_FIRST, WR_W_LAST: begin
                    // B before WLAST ends the slot as a protocol error
                    if (bus.b_hs_i)          phase_d = WR_IDLE;
                    else if (bus.w_beat_i)   phase_d = bus.w_last_i ? WR_B_WAIT : WR_W_LAST;
                end
                WR_B_WAIT: begin
                    if (bus.b_hs_i) phase_d = WR_IDLE;
                end
                default: phase_d = WR_IDLE;
            endcase
        end
    end

    // Datapath, flag and budget-control logic
    always_comb begin
        id_d         = id_q;
        len_d        = len_q;
        beats_d      = beats_q;
        flags_d      = flags_q;
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        alloc_err_d  = bus.alloc_i && busy_c;
        free_d       = (phase_d == WR_IDLE);

        if (bus.clear_i) begin
            cnt_clr = 1'b1;
        end else begin
            unique case (phase_q)
                WR_IDLE: begin
                    if (bus.alloc_i) begin
                        id_d     = bus.alloc_id_i;
                        len_d    = bus.alloc_len_i;
                        beats_d  = '0;
                        flags_d  = '0;
                        cnt_load = 1'b1;
                        if (!bus.w_beat_i) begin
                            cnt_load_val = bus.budget_w_i;
                        end else begin
                            beats_d         = beat_next_c;
                            flags_d[ErrLen] = len_bad_c;
                            cnt_load_val    = bus.w_last_i ? bus.budget_b_i : bus.budget_last_i;
                        end
                    end
                end
                WR_W_FIRST, WR_W_LAST: begin
                    if (bus.b_hs_i) begin
                        flags_d[ErrProto] = 1'b1;
                        cnt_clr           = 1'b1;
                    end else if (bus.w_beat_i) begin
                        beats_d         = beat_next_c;
                        flags_d[ErrLen] = flags_q[ErrLen] | len_bad_c;
                        cnt_load        = 1'b1;
                        cnt_load_val    = bus.w_last_i ? bus.budget_b_i : bus.budget_last_i;
                    end
                end
                WR_B_WAIT: begin
                    if (bus.b_hs_i) cnt_clr = 1'b1;
                end
                default: cnt_clr = 1'b1;
            endcase
        end

        if (cnt_expired_c) flags_d[ErrTimeout] = 1'b1;
    end

    assign bus.free_o      = free_q;
    assign bus.id_o        = id_q;
    assign bus.phase_o     = phase_q;
    assign bus.counter_o   = cnt_value;
    assign bus.timeout_o   = flags_q[ErrTimeout];
    assign bus.len_err_o   = flags_q[ErrLen];
    assign bus.proto_err_o = flags_q[ErrProto];
    assign bus.alloc_err_o = alloc_err_q;

endmodule

// File: tb/tb_wr_txn_tracker.sv
// Self-checking bench for wr_txn_tracker: transaction-level model checked every
// cycle, plus hand-computed literal expectations along the directed scenarios.
module tb_wr_txn_tracker;
    import axi_monitor_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    wr_txn_tracker_if bus_if ();

    wr_txn_tracker dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    // Model state: a slot seen as "which phase, what is left, what went wrong"
    int m_phase = 0, m_id = 0, m_len = 0, m_beats = 0, m_cnt = 0;
    bit m_to = 0, m_le = 0, m_pe = 0, m_ae = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_id = 0; m_len = 0; m_beats = 0; m_cnt = 0;
            m_to = 0; m_le = 0; m_pe = 0; m_ae = 0;
        end else begin
            int  old_phase;
            bit  reloaded;
            old_phase = m_phase;
            reloaded  = 0;
            m_ae = bus_if.alloc_i && (old_phase != 0);
            if (bus_if.clear_i) begin
                m_phase = 0; m_cnt = 0; reloaded = 1;
            end else if (old_phase == 0) begin
                if (bus_if.alloc_i) begin
                    m_id = int'(bus_if.alloc_id_i); m_len = int'(bus_if.alloc_len_i);
                    m_beats = 0; m_to = 0; m_le = 0; m_pe = 0;
                    if (!bus_if.w_beat_i) begin
                        m_phase = 1; m_cnt = int'(bus_if.budget_w_i);
                    end else begin
                        m_beats = 1;
                        if (bus_if.w_last_i) begin
                            m_phase = 3; m_cnt = int'(bus_if.budget_b_i); m_le = (m_beats != m_len + 1);
                        end else begin
                            m_phase = 2; m_cnt = int'(bus_if.budget_last_i);
                        end
                    end
                end
            end else if (old_phase == 3) begin
                if (bus_if.b_hs_i) begin m_phase = 0; m_cnt = 0; reloaded = 1; end
            end else begin
                if (bus_if.b_hs_i) begin
                    m_pe = 1; m_phase = 0; m_cnt = 0; reloaded = 1;
                end else if (bus_if.w_beat_i) begin
                    m_beats = (m_beats < 511) ? m_beats + 1 : 511;
                    reloaded = 1;
                    if (bus_if.w_last_i) begin
                        if (m_beats != m_len + 1) m_le = 1;
                        m_phase = 3; m_cnt = int'(bus_if.budget_b_i);
                    end else begin
                        if (m_beats > m_len + 1) m_le = 1;
                        m_phase = 2; m_cnt = int'(bus_if.budget_last_i);
                    end
                end
            end
            if (old_phase != 0 && !reloaded && bus_if.prescaled_en_i) begin
                if (m_cnt == 0) m_to = 1;
                else            m_cnt = m_cnt - 1;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("free",      int'(bus_if.free_o),      int'(m_phase == 0));
            cmp("id",        int'(bus_if.id_o),        m_id);
            cmp("phase",     int'(bus_if.phase_o),     m_phase);
            cmp("counter",   int'(bus_if.counter_o),   m_cnt);
            cmp("timeout",   int'(bus_if.timeout_o),   int'(m_to));
            cmp("len_err",   int'(bus_if.len_err_o),   int'(m_le));
            cmp("proto_err", int'(bus_if.proto_err_o), int'(m_pe));
            cmp("alloc_err", int'(bus_if.alloc_err_o), int'(m_ae));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus_if.prescaled_en_i = 0; bus_if.alloc_i = 0;
        bus_if.w_beat_i = 0; bus_if.w_last_i = 0;
        bus_if.b_hs_i = 0; bus_if.clear_i = 0;
    endtask

    task automatic alloc(input int id, input int len, input bit wb, input bit wl);
        bus_if.alloc_i = 1; bus_if.alloc_id_i = 4'(id); bus_if.alloc_len_i = 8'(len);
        bus_if.w_beat_i = wb; bus_if.w_last_i = wl;
        cyc();
        bus_if.alloc_i = 0; bus_if.w_beat_i = 0; bus_if.w_last_i = 0;
    endtask

    task automatic beat(input bit last);
        bus_if.w_beat_i = 1; bus_if.w_last_i = last;
        cyc();
        bus_if.w_beat_i = 0; bus_if.w_last_i = 0;
    endtask

    task automatic bresp();
        bus_if.b_hs_i = 1;
        cyc();
        bus_if.b_hs_i = 0;
    endtask

    initial begin
        idle_inputs();
        bus_if.alloc_id_i = '0; bus_if.alloc_len_i = '0;
        bus_if.budget_w_i = 10'd5; bus_if.budget_last_i = 10'd4; bus_if.budget_b_i = 10'd6;
        cyc(2);
        cmp("rst_free",    int'(bus_if.free_o), 1);
        cmp("rst_phase",   int'(bus_if.phase_o), 0);
        cmp("rst_counter", int'(bus_if.counter_o), 0);
        rst_n = 1;
        chk_en = 1;
        cyc();

        // 1. Nominal burst id=3 len=3
        alloc(3, 3, 0, 0);
        cmp("t1_phase_wfirst", int'(bus_if.phase_o), 1);
        cmp("t1_counter_w",    int'(bus_if.counter_o), 5);
        cmp("t1_id",           int'(bus_if.id_o), 3);
        cmp("t1_free_busy",    int'(bus_if.free_o), 0);
        beat(0);
        cmp("t1_phase_wlast",  int'(bus_if.phase_o), 2);
        cmp("t1_counter_last", int'(bus_if.counter_o), 4);
        beat(0); beat(0); beat(1);
        cmp("t1_phase_bwait",  int'(bus_if.phase_o), 3);
        cmp("t1_counter_b",    int'(bus_if.counter_o), 6);
        cyc(4);
        bresp();
        cmp("t1_phase_idle",   int'(bus_if.phase_o), 0);
        cmp("t1_free_after_b", int'(bus_if.free_o), 1);
        cmp("t1_no_len_err",   int'(bus_if.len_err_o), 0);
        cmp("t1_no_timeout",   int'(bus_if.timeout_o), 0);

        // 2. W timeout with budget 2 and a tick every cycle
        bus_if.budget_w_i = 10'd2;
        bus_if.prescaled_en_i = 1;
        alloc(1, 0, 0, 0);
        cmp("t2_counter2", int'(bus_if.counter_o), 2);
        cyc();
        cmp("t2_counter1", int'(bus_if.counter_o), 1);
        cyc();
        cmp("t2_counter0", int'(bus_if.counter_o), 0);
        cmp("t2_no_to_yet", int'(bus_if.timeout_o), 0);
        cyc();
        cmp("t2_timeout",   int'(bus_if.timeout_o), 1);
        cmp("t2_phase_hold", int'(bus_if.phase_o), 1);
        bus_if.prescaled_en_i = 0;
        bus_if.clear_i = 1; cyc(); bus_if.clear_i = 0;
        cmp("t2_clear_idle",   int'(bus_if.phase_o), 0);
        cmp("t2_timeout_kept", int'(bus_if.timeout_o), 1);

        // Budget 0 at phase entry: timeout on the first tick
        bus_if.budget_w_i = 10'd0;
        alloc(2, 0, 0, 0);
        cmp("t2b_to_cleared", int'(bus_if.timeout_o), 0);
        bus_if.prescaled_en_i = 1; cyc(); bus_if.prescaled_en_i = 0;
        cmp("t2b_timeout", int'(bus_if.timeout_o), 1);
        bus_if.clear_i = 1; cyc(); bus_if.clear_i = 0;
        bus_if.budget_w_i = 10'd5;

        // 3. Same-cycle AW + single last beat
        alloc(5, 0, 1, 1);
        cmp("t3_phase_bwait", int'(bus_if.phase_o), 3);
        cmp("t3_counter_b",   int'(bus_if.counter_o), 6);
        cmp("t3_len_ok",      int'(bus_if.len_err_o), 0);
        cmp("t3_to_cleared",  int'(bus_if.timeout_o), 0);
        bresp();

        // 4. Length mismatch: too many beats, then too few
        alloc(6, 1, 0, 0);
        beat(0); beat(0);
        cmp("t4_len_ok_mid", int'(bus_if.len_err_o), 0);
        beat(1);
        cmp("t4_len_long",   int'(bus_if.len_err_o), 1);
        cmp("t4_phase_b",    int'(bus_if.phase_o), 3);
        bresp();
        alloc(7, 3, 0, 0);
        cmp("t4_len_cleared", int'(bus_if.len_err_o), 0);
        beat(0); beat(1);
        cmp("t4_len_short",  int'(bus_if.len_err_o), 1);
        bresp();

        // Longest burst: len=255 needs 256 beats, no wrap
        alloc(8, 255, 0, 0);
        for (int i = 0; i < 255; i++) beat(0);
        cmp("t4_long_no_err", int'(bus_if.len_err_o), 0);
        beat(1);
        cmp("t4_long_ok",  int'(bus_if.len_err_o), 0);
        cmp("t4_long_b",   int'(bus_if.phase_o), 3);
        bresp();

        // 5. Early B during W_LAST, then alloc while busy
        alloc(4, 3, 0, 0);
        beat(0);
        bresp();
        cmp("t5_proto_err", int'(bus_if.proto_err_o), 1);
        cmp("t5_free",      int'(bus_if.free_o), 1);
        alloc(10, 2, 0, 0);
        cmp("t5_proto_cleared", int'(bus_if.proto_err_o), 0);
        alloc(9, 7, 0, 0);
        cmp("t5_alloc_err",   int'(bus_if.alloc_err_o), 1);
        cmp("t5_id_kept",     int'(bus_if.id_o), 10);
        cmp("t5_phase_kept",  int'(bus_if.phase_o), 1);
        cyc();
        cmp("t5_alloc_err_pulse", int'(bus_if.alloc_err_o), 0);

        // 6. Abort with a beat and a tick in the same cycle
        bus_if.clear_i = 1; bus_if.w_beat_i = 1; bus_if.prescaled_en_i = 1;
        cyc();
        idle_inputs();
        cmp("t6_clear_phase",   int'(bus_if.phase_o), 0);
        cmp("t6_clear_counter", int'(bus_if.counter_o), 0);

        // Asynchronous reset while in B_WAIT
        alloc(12, 0, 1, 1);
        cmp("t6_bwait", int'(bus_if.phase_o), 3);
        #2 rst_n = 0;
        #1;
        cmp("t6_rst_free",    int'(bus_if.free_o), 1);
        cmp("t6_rst_phase",   int'(bus_if.phase_o), 0);
        cmp("t6_rst_counter", int'(bus_if.counter_o), 0);
        cmp("t6_rst_id",      int'(bus_if.id_o), 0);
        #1 rst_n = 1;
        cyc(2);
        alloc(1, 0, 0, 0);
        cmp("t6_after_rst", int'(bus_if.phase_o), 1);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
